// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush sequencer for the 16-bit CPU
// Resolves load-use stalls, taken-branch flushes and data-memory waits with Mealy enables.
module pipeline_hazard_ctrl #(
    parameter int REG_AW     = 3,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              pc_reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_write,
    output logic              id_ex_flush,
    output logic              ex_mem_write,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [2:0] LOAD_RELOAD = 3'(LOAD_LAT - 1);
    localparam logic [2:0] BR_RELOAD   = 3'(BR_PENALTY - 1);

    state_t            state_q, state_d;
    state_t            resume_q, resume_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic memstall;
    logic freeze;
    logic pc_write_c, if_id_write_c, if_id_flush_c;
    logic id_ex_write_c, id_ex_flush_c, ex_mem_write_c;

    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign memstall = mem_req && !mem_ready;

    always_comb begin
        state_d        = state_q;
        resume_d       = resume_q;
        cnt_d          = cnt_q;
        freeze         = 1'b0;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_write_c  = 1'b1;
        id_ex_flush_c  = 1'b0;
        ex_mem_write_c = 1'b1;

        case (state_q)
            RUN: begin
                if (memstall) begin
                    freeze   = 1'b1;
                    state_d  = MEM_WAIT;
                    resume_d = RUN;
                end else if (ex_branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_d = BR_FLUSH;
                        cnt_d   = BR_RELOAD;
                    end
                end else if (hazard) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_flush_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = LOAD_RELOAD;
                    end
                end
            end
            LOAD_STALL: begin
                // A data-memory wait freezes the whole pipe; the bubble count resumes afterwards.
                if (memstall) begin
                    freeze   = 1'b1;
                    state_d  = MEM_WAIT;
                    resume_d = LOAD_STALL;
                end else begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_flush_c = 1'b1;
                    cnt_d         = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            BR_FLUSH: begin
                if (memstall) begin
                    freeze   = 1'b1;
                    state_d  = MEM_WAIT;
                    resume_d = BR_FLUSH;
                end else if (ex_branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                    cnt_d         = BR_RELOAD;
                end else begin
                    if_id_flush_c = 1'b1;
                    cnt_d         = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze = 1'b1;
                end else begin
                    state_d = resume_q;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Freeze holds every stage in place; ID_EX keeps its content rather than taking a bubble.
        if (freeze) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            if_id_flush_c  = 1'b0;
            id_ex_write_c  = 1'b0;
            id_ex_flush_c  = 1'b0;
            ex_mem_write_c = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge pc_reset) begin
        if (!pc_reset) begin
            state_q     <= RUN;
            resume_q    <= RUN;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // While reset is held the pipe is frozen and both pipe registers are cleared.
    assign pc_write     = pc_reset & pc_write_c;
    assign if_id_write  = pc_reset & if_id_write_c;
    assign if_id_flush  = ~pc_reset | if_id_flush_c;
    assign id_ex_write  = pc_reset & id_ex_write_c;
    assign id_ex_flush  = ~pc_reset | id_ex_flush_c;
    assign ex_mem_write = pc_reset & ex_mem_write_c;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
// Two instances: defaults (A) and LOAD_LAT=3/BR_PENALTY=2/CNT_W=4 (B), sharing stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       pc_reset;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

    logic        pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a;
    logic        pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b;
    logic [15:0] sc_a;
    logic [3:0]  sc_b;
    logic [5:0]  ctl_a, ctl_b;

    int n_cmp = 0;
    int n_bad = 0;

    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write}
    localparam logic [5:0] C_RST    = 6'b001010;
    localparam logic [5:0] C_RUN    = 6'b110101;
    localparam logic [5:0] C_HAZ    = 6'b000111;
    localparam logic [5:0] C_BR     = 6'b111111;
    localparam logic [5:0] C_BRTAIL = 6'b111101;
    localparam logic [5:0] C_FRZ    = 6'b000000;

    assign ctl_a = {pcw_a, ifw_a, iff_a, idw_a, idf_a, exw_a};
    assign ctl_b = {pcw_b, ifw_b, iff_b, idw_b, idf_b, exw_b};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_dut_a (
        .clk(clk), .pc_reset(pc_reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pcw_a), .if_id_write(ifw_a), .if_id_flush(iff_a),
        .id_ex_write(idw_a), .id_ex_flush(idf_a), .ex_mem_write(exw_a), .stall_count(sc_a)
    );

    pipeline_hazard_ctrl #(.REG_AW(3), .LOAD_LAT(3), .BR_PENALTY(2), .CNT_W(4)) u_dut_b (
        .clk(clk), .pc_reset(pc_reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pcw_b), .if_id_write(ifw_b), .if_id_flush(iff_b),
        .id_ex_write(idw_b), .id_ex_flush(idf_b), .ex_mem_write(exw_b), .stall_count(sc_b)
    );

    task automatic idle();
        id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        pc_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pc_reset = 1'b1;
    endtask

    task automatic set_load_use(input logic [2:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = 3'd3; id_uses_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        pc_reset = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (ctl_a !== C_RST) begin n_bad++; $display("FAIL reset_ctl_a got %b exp %b", ctl_a, C_RST); end
        n_cmp++; if (sc_a !== 16'd0) begin n_bad++; $display("FAIL reset_sc_a got %0d exp 0", sc_a); end
        n_cmp++; if (ctl_b !== C_RST) begin n_bad++; $display("FAIL reset_ctl_b got %b exp %b", ctl_b, C_RST); end
        @(negedge clk);
        pc_reset = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL reset_release_a got %b exp %b", ctl_a, C_RUN); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(3'd3);
        #1;
        n_cmp++; if (ctl_a !== C_HAZ) begin n_bad++; $display("FAIL lu_ctl_a got %b exp %b", ctl_a, C_HAZ); end
        n_cmp++; if (ctl_b !== C_HAZ) begin n_bad++; $display("FAIL lu_ctl_b0 got %b exp %b", ctl_b, C_HAZ); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL lu_after_a got %b exp %b", ctl_a, C_RUN); end
        n_cmp++; if (sc_a !== 16'd1) begin n_bad++; $display("FAIL lu_sc_a got %0d exp 1", sc_a); end
        n_cmp++; if (ctl_b !== C_HAZ) begin n_bad++; $display("FAIL lu_ctl_b1 got %b exp %b", ctl_b, C_HAZ); end
        @(negedge clk);
        #1;
        n_cmp++; if (ctl_b !== C_HAZ) begin n_bad++; $display("FAIL lu_ctl_b2 got %b exp %b", ctl_b, C_HAZ); end
        @(negedge clk);
        #1;
        n_cmp++; if (ctl_b !== C_RUN) begin n_bad++; $display("FAIL lu_ctl_b3 got %b exp %b", ctl_b, C_RUN); end
        n_cmp++; if (sc_b !== 4'd3) begin n_bad++; $display("FAIL lu_sc_b got %0d exp 3", sc_b); end
    endtask

    task automatic test_r0_and_unused();
        do_reset();
        set_load_use(3'd0);
        id_rs1 = 3'd0;
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL r0_ctl_a got %b exp %b", ctl_a, C_RUN); end
        @(negedge clk);
        set_load_use(3'd3);
        id_uses_rs1 = 1'b0;
        id_rs2 = 3'd3;
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL unused_ctl_a got %b exp %b", ctl_a, C_RUN); end
        @(negedge clk);
        id_rs1 = 3'd5;
        id_uses_rs2 = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_HAZ) begin n_bad++; $display("FAIL rs2_ctl_a got %b exp %b", ctl_a, C_HAZ); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (sc_a !== 16'd1) begin n_bad++; $display("FAIL r0_sc_a got %0d exp 1", sc_a); end
    endtask

    task automatic test_branch();
        do_reset();
        ex_branch_taken = 1'b1;
        #1;
        n_cmp++; if (ctl_b !== C_BR) begin n_bad++; $display("FAIL br_b0 got %b exp %b", ctl_b, C_BR); end
        n_cmp++; if (ctl_a !== C_BR) begin n_bad++; $display("FAIL br_a0 got %b exp %b", ctl_a, C_BR); end
        @(negedge clk);
        ex_branch_taken = 1'b0;
        #1;
        n_cmp++; if (ctl_b !== C_BRTAIL) begin n_bad++; $display("FAIL br_b1 got %b exp %b", ctl_b, C_BRTAIL); end
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL br_a1 got %b exp %b", ctl_a, C_RUN); end
        @(negedge clk);
        #1;
        n_cmp++; if (ctl_b !== C_RUN) begin n_bad++; $display("FAIL br_b2 got %b exp %b", ctl_b, C_RUN); end
        n_cmp++; if (sc_b !== 4'd0) begin n_bad++; $display("FAIL br_sc_b got %0d exp 0", sc_b); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (ctl_a !== C_FRZ) begin n_bad++; $display("FAIL mw_frz%0d got %b exp %b", i, ctl_a, C_FRZ); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL mw_release got %b exp %b", ctl_a, C_RUN); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (sc_a !== 16'd3) begin n_bad++; $display("FAIL mw_sc_a got %0d exp 3", sc_a); end
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL mw_after got %b exp %b", ctl_a, C_RUN); end
    endtask

    task automatic test_mem_vs_branch();
        do_reset();
        mem_req = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_FRZ) begin n_bad++; $display("FAIL mb_frz0 got %b exp %b", ctl_a, C_FRZ); end
        @(negedge clk);
        #1;
        n_cmp++; if (ctl_a !== C_FRZ) begin n_bad++; $display("FAIL mb_frz1 got %b exp %b", ctl_a, C_FRZ); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL mb_release got %b exp %b", ctl_a, C_RUN); end
        @(negedge clk);
        mem_req = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_cmp++; if (ctl_a !== C_BR) begin n_bad++; $display("FAIL mb_flush got %b exp %b", ctl_a, C_BR); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_preempt_load();
        do_reset();
        set_load_use(3'd3);
        @(negedge clk);
        idle();
        mem_req = 1'b1;
        #1;
        n_cmp++; if (ctl_b !== C_FRZ) begin n_bad++; $display("FAIL pl_frz got %b exp %b", ctl_b, C_FRZ); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        n_cmp++; if (ctl_b !== C_RUN) begin n_bad++; $display("FAIL pl_release got %b exp %b", ctl_b, C_RUN); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (ctl_b !== C_HAZ) begin n_bad++; $display("FAIL pl_resume0 got %b exp %b", ctl_b, C_HAZ); end
        @(negedge clk);
        #1;
        n_cmp++; if (ctl_b !== C_HAZ) begin n_bad++; $display("FAIL pl_resume1 got %b exp %b", ctl_b, C_HAZ); end
        @(negedge clk);
        #1;
        n_cmp++; if (ctl_b !== C_RUN) begin n_bad++; $display("FAIL pl_done got %b exp %b", ctl_b, C_RUN); end
        n_cmp++; if (sc_b !== 4'd4) begin n_bad++; $display("FAIL pl_sc_b got %0d exp 4", sc_b); end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        n_cmp++; if (sc_a !== 16'd20) begin n_bad++; $display("FAIL sat_sc_a got %0d exp 20", sc_a); end
        n_cmp++; if (sc_b !== 4'd15) begin n_bad++; $display("FAIL sat_sc_b got %0d exp 15", sc_b); end
        pc_reset = 1'b0;
        #1;
        n_cmp++; if (sc_a !== 16'd0) begin n_bad++; $display("FAIL rst_mid_sc_a got %0d exp 0", sc_a); end
        n_cmp++; if (ctl_a !== C_RST) begin n_bad++; $display("FAIL rst_mid_ctl_a got %b exp %b", ctl_a, C_RST); end
        @(negedge clk);
        idle();
        pc_reset = 1'b1;
        #1;
        n_cmp++; if (ctl_a !== C_RUN) begin n_bad++; $display("FAIL rst_mid_run got %b exp %b", ctl_a, C_RUN); end
        @(negedge clk);
        #1;
        n_cmp++; if (sc_b !== 4'd0) begin n_bad++; $display("FAIL rst_mid_sc_b got %0d exp 0", sc_b); end
    endtask

    initial begin
        idle();
        pc_reset = 1'b0;
        test_reset();
        test_load_use();
        test_r0_and_unused();
        test_branch();
        test_mem_wait();
        test_mem_vs_branch();
        test_preempt_load();
        test_saturate_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
